// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load control/status
// between the program source and the loader.
interface imem_loader_if #(
   parameter int unsigned CNT_W = 9
);
   logic             load_start;
   logic [CNT_W-1:0] load_words;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             busy;
   logic             cpu_run;
   logic             load_err;

   modport master (
      output load_start, load_words, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_run, load_err
   );

   modport slave (
      input  load_start, load_words, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_run, load_err
   );
endinterface

// File: rtl/imem_loader.sv
// Streams a byte-serial program into instruction memory as big-endian words and
// holds the CPU in reset (cpu_run low) until the whole program is written.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 9
) (
   input logic          clock,
   input logic          reset,
   imem_loader_if.slave ldr
);
   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WORDS);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} stateT;

   stateT            state, nextState;
   logic [31:0]      shiftReg, nextShift;
   logic [1:0]       byteCnt, nextByteCnt;
   logic [CNT_W-1:0] wordIndex, nextWordIndex;
   logic [CNT_W-1:0] lenReg, nextLen;
   logic [31:0]      memAddr, nextAddr;
   logic [31:0]      memWdata, nextWdata;
   logic             memWe, nextWe;
   logic             loadErr, nextErr;
   logic             byteReady, busy, cpuRun;

   // State register plus registered outputs derived from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shiftReg  <= '0;
         byteCnt   <= '0;
         wordIndex <= '0;
         lenReg    <= '0;
         memAddr   <= '0;
         memWdata  <= '0;
         memWe     <= 1'b0;
         loadErr   <= 1'b0;
         byteReady <= 1'b0;
         busy      <= 1'b0;
         cpuRun    <= 1'b0;
      end else begin
         state     <= nextState;
         shiftReg  <= nextShift;
         byteCnt   <= nextByteCnt;
         wordIndex <= nextWordIndex;
         lenReg    <= nextLen;
         memAddr   <= nextAddr;
         memWdata  <= nextWdata;
         memWe     <= nextWe;
         loadErr   <= nextErr;
         byteReady <= (nextState == RECV);
         busy      <= (nextState == RECV) || (nextState == WRITE);
         cpuRun    <= (nextState == DONE);
      end
   end

   always_comb begin
      nextState     = state;
      nextShift     = shiftReg;
      nextByteCnt   = byteCnt;
      nextWordIndex = wordIndex;
      nextLen       = lenReg;
      nextAddr      = memAddr;
      nextWdata     = memWdata;
      nextWe        = 1'b0;
      nextErr       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (ldr.load_start) begin
               if (ldr.load_words == '0) begin
                  nextState = DONE;
               end else if (ldr.load_words > MAX_LEN) begin
                  nextErr = 1'b1;
               end else begin
                  nextLen       = ldr.load_words;
                  nextWordIndex = '0;
                  nextByteCnt   = '0;
                  nextState     = RECV;
               end
            end
         end
         RECV: begin
            if (ldr.byte_valid && byteReady) begin
               nextShift   = {shiftReg[23:0], ldr.byte_in};
               nextByteCnt = byteCnt + 2'd1;
               // Fourth byte completes the word: present it on the write port next cycle
               if (byteCnt == 2'd3) begin
                  nextState = WRITE;
                  nextWe    = 1'b1;
                  nextWdata = {shiftReg[23:0], ldr.byte_in};
                  nextAddr  = BASE_ADDR + 32'({wordIndex, 2'b00});
               end
            end
         end
         WRITE: begin
            if (wordIndex + CNT_W'(1) == lenReg) begin
               nextState = DONE;
            end else begin
               nextWordIndex = wordIndex + CNT_W'(1);
               nextState     = RECV;
            end
         end
      endcase
   end

   assign ldr.byte_ready = byteReady;
   assign ldr.mem_we     = memWe;
   assign ldr.mem_addr   = memAddr;
   assign ldr.mem_wdata  = memWdata;
   assign ldr.busy       = busy;
   assign ldr.cpu_run    = cpuRun;
   assign ldr.load_err   = loadErr;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one DUT at base 0 and a twin at base FFFFFFFC
// fed from the same stimulus to exercise address wrap-around.
module tb_imem_loader;
   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   startCyc = 0;

   int          logCyc[$];
   logic [31:0] logAddr[$];
   logic [31:0] logData[$];
   logic [31:0] logAddr1[$];

   imem_loader_if #(.CNT_W(9)) bus0();
   imem_loader_if #(.CNT_W(9)) bus1();

   imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256), .CNT_W(9)) dut0 (
      .clock(clock), .reset(reset), .ldr(bus0)
   );
   imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(256), .CNT_W(9)) dut1 (
      .clock(clock), .reset(reset), .ldr(bus1)
   );

   assign bus1.load_start = bus0.load_start;
   assign bus1.load_words = bus0.load_words;
   assign bus1.byte_in    = bus0.byte_in;
   assign bus1.byte_valid = bus0.byte_valid;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Record every write pulse seen by either DUT
   always @(negedge clock) begin
      if (bus0.mem_we === 1'b1) begin
         logCyc.push_back(cyc);
         logAddr.push_back(bus0.mem_addr);
         logData.push_back(bus0.mem_wdata);
      end
      if (bus1.mem_we === 1'b1) logAddr1.push_back(bus1.mem_addr);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clearLog();
      logCyc.delete();
      logAddr.delete();
      logData.delete();
      logAddr1.delete();
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus0.load_start = 1'b0;
      bus0.load_words = '0;
      bus0.byte_in    = '0;
      bus0.byte_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic startLoad(input int unsigned words);
      bus0.load_start = 1'b1;
      bus0.load_words = 9'(words);
      tick();
      bus0.load_start = 1'b0;
      startCyc = cyc - 1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int n;
      n = 0;
      bus0.byte_in    = b;
      bus0.byte_valid = 1'b1;
      while (bus0.byte_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (bus0.byte_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_timeout byte=%h byte_ready=%b want 1 within 20 cycles", b, bus0.byte_ready);
      end
      tick();
      bus0.byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus0.load_start = 1'b0;
      bus0.load_words = '0;
      bus0.byte_in    = '0;
      bus0.byte_valid = 1'b0;
      tick();
      total++;
      if ({bus0.byte_ready, bus0.mem_we, bus0.busy, bus0.cpu_run, bus0.load_err} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {bus0.byte_ready, bus0.mem_we, bus0.busy, bus0.cpu_run, bus0.load_err});
      end
      total++;
      if (bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_bus addr=%h data=%h want 0/0", bus0.mem_addr, bus0.mem_wdata);
      end
      total++;
      if (bus1.mem_addr !== 32'h0 || bus1.cpu_run !== 1'b0) begin
         bad++;
         $display("FAIL reset_dut1 addr=%h cpu_run=%b want 0/0", bus1.mem_addr, bus1.cpu_run);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] prog [8];
      prog = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
      doReset();
      clearLog();
      startLoad(2);
      total++;
      if (bus0.busy !== 1'b1 || bus0.byte_ready !== 1'b1 || bus0.cpu_run !== 1'b0) begin
         bad++;
         $display("FAIL basic_enter busy=%b ready=%b run=%b want 1/1/0", bus0.busy, bus0.byte_ready, bus0.cpu_run);
      end
      for (int i = 0; i < 8; i++) sendByte(prog[i]);
      total++;
      if (cyc - startCyc != 10 || bus0.mem_we !== 1'b1 || bus0.byte_ready !== 1'b0 || bus0.cpu_run !== 1'b0) begin
         bad++;
         $display("FAIL basic_last_write rel=%0d we=%b ready=%b run=%b want 10/1/0/0",
                  cyc - startCyc, bus0.mem_we, bus0.byte_ready, bus0.cpu_run);
      end
      tick();
      total++;
      if (cyc - startCyc != 11 || bus0.cpu_run !== 1'b1 || bus0.busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_run rel=%0d run=%b busy=%b want 11/1/0", cyc - startCyc, bus0.cpu_run, bus0.busy);
      end
      total++;
      if (logAddr.size() != 2) begin
         bad++;
         $display("FAIL basic_write_count got=%0d want=2", logAddr.size());
      end else begin
         total++;
         if (logCyc[0] - startCyc != 5 || logCyc[1] - startCyc != 10) begin
            bad++;
            $display("FAIL basic_write_cycles got=%0d,%0d want=5,10", logCyc[0] - startCyc, logCyc[1] - startCyc);
         end
         total++;
         if (logAddr[0] !== 32'h0 || logData[0] !== 32'h8C01_0004) begin
            bad++;
            $display("FAIL basic_word0 got=%h@%h want=8c010004@00000000", logData[0], logAddr[0]);
         end
         total++;
         if (logAddr[1] !== 32'h4 || logData[1] !== 32'hAC02_0008) begin
            bad++;
            $display("FAIL basic_word1 got=%h@%h want=ac020008@00000004", logData[1], logAddr[1]);
         end
      end
      total++;
      if (logAddr1.size() != 2) begin
         bad++;
         $display("FAIL wrap_count got=%0d want=2", logAddr1.size());
      end else begin
         total++;
         if (logAddr1[0] !== 32'hFFFF_FFFC || logAddr1[1] !== 32'h0) begin
            bad++;
            $display("FAIL wrap_addr got=%h,%h want=fffffffc,00000000", logAddr1[0], logAddr1[1]);
         end
      end
      total++;
      if (bus0.mem_we !== 1'b0 || bus0.mem_addr !== 32'h4 || bus0.mem_wdata !== 32'hAC02_0008) begin
         bad++;
         $display("FAIL basic_hold we=%b addr=%h data=%h want 0/00000004/ac020008",
                  bus0.mem_we, bus0.mem_addr, bus0.mem_wdata);
      end
   endtask

   task automatic test_stall();
      doReset();
      clearLog();
      startLoad(2);
      sendByte(8'h8C);
      sendByte(8'h01);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (bus0.byte_ready !== 1'b1 || bus0.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL stall_wait%0d ready=%b we=%b want 1/0", i, bus0.byte_ready, bus0.mem_we);
         end
      end
      sendByte(8'h00);
      sendByte(8'h04);
      total++;
      if (cyc - startCyc != 8 || bus0.mem_we !== 1'b1 || bus0.mem_wdata !== 32'h8C01_0004) begin
         bad++;
         $display("FAIL stall_word0 rel=%0d we=%b data=%h want 8/1/8c010004",
                  cyc - startCyc, bus0.mem_we, bus0.mem_wdata);
      end
      sendByte(8'hAC);
      sendByte(8'h02);
      sendByte(8'h00);
      sendByte(8'h08);
      tick();
      total++;
      if (logData.size() != 2 || bus0.cpu_run !== 1'b1) begin
         bad++;
         $display("FAIL stall_done writes=%0d run=%b want 2/1", logData.size(), bus0.cpu_run);
      end else begin
         total++;
         if (logData[1] !== 32'hAC02_0008 || logAddr[1] !== 32'h4 || logCyc[1] - startCyc != 13) begin
            bad++;
            $display("FAIL stall_word1 got=%h@%h rel=%0d want=ac020008@00000004 rel=13",
                     logData[1], logAddr[1], logCyc[1] - startCyc);
         end
      end
   endtask

   task automatic test_zero_err();
      doReset();
      clearLog();
      startLoad(0);
      total++;
      if (bus0.cpu_run !== 1'b1 || bus0.busy !== 1'b0 || bus0.byte_ready !== 1'b0) begin
         bad++;
         $display("FAIL zero_len run=%b busy=%b ready=%b want 1/0/0", bus0.cpu_run, bus0.busy, bus0.byte_ready);
      end
      repeat (3) tick();
      total++;
      if (bus0.cpu_run !== 1'b1 || logAddr.size() != 0) begin
         bad++;
         $display("FAIL zero_hold run=%b writes=%0d want 1/0", bus0.cpu_run, logAddr.size());
      end
      startLoad(257);
      total++;
      if (bus0.load_err !== 1'b1 || bus0.cpu_run !== 1'b1) begin
         bad++;
         $display("FAIL err_in_done err=%b run=%b want 1/1", bus0.load_err, bus0.cpu_run);
      end
      doReset();
      startLoad(257);
      total++;
      if (bus0.load_err !== 1'b1 || bus0.cpu_run !== 1'b0 || bus0.busy !== 1'b0) begin
         bad++;
         $display("FAIL err_idle err=%b run=%b busy=%b want 1/0/0", bus0.load_err, bus0.cpu_run, bus0.busy);
      end
      tick();
      total++;
      if (bus0.load_err !== 1'b0 || bus0.cpu_run !== 1'b0 || bus0.busy !== 1'b0) begin
         bad++;
         $display("FAIL err_pulse err=%b run=%b busy=%b want 0/0/0", bus0.load_err, bus0.cpu_run, bus0.busy);
      end
      startLoad(256);
      total++;
      if (bus0.busy !== 1'b1 || bus0.load_err !== 1'b0) begin
         bad++;
         $display("FAIL max_len busy=%b err=%b want 1/0", bus0.busy, bus0.load_err);
      end
   endtask

   task automatic test_abort();
      doReset();
      clearLog();
      startLoad(2);
      sendByte(8'h8C);
      sendByte(8'h01);
      sendByte(8'h00);
      sendByte(8'h04);
      sendByte(8'hAC);
      sendByte(8'h02);
      reset = 1'b1;
      bus0.byte_valid = 1'b1;
      bus0.byte_in    = 8'h00;
      tick();
      total++;
      if ({bus0.byte_ready, bus0.mem_we, bus0.busy, bus0.cpu_run, bus0.load_err} !== 5'b0 ||
          bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL abort_outputs ctrl=%b addr=%h data=%h want 00000/0/0",
                  {bus0.byte_ready, bus0.mem_we, bus0.busy, bus0.cpu_run, bus0.load_err},
                  bus0.mem_addr, bus0.mem_wdata);
      end
      reset = 1'b0;
      repeat (6) tick();
      bus0.byte_valid = 1'b0;
      total++;
      if (logAddr.size() != 1 || bus0.busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_no_write writes=%0d busy=%b want 1/0", logAddr.size(), bus0.busy);
      end
      clearLog();
      startLoad(1);
      sendByte(8'h12);
      sendByte(8'h34);
      sendByte(8'h56);
      sendByte(8'h78);
      total++;
      if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h1234_5678) begin
         bad++;
         $display("FAIL abort_restart we=%b got=%h@%h want 1 12345678@00000000",
                  bus0.mem_we, bus0.mem_wdata, bus0.mem_addr);
      end
      tick();
   endtask

   task automatic test_reload();
      total++;
      if (bus0.cpu_run !== 1'b1) begin
         bad++;
         $display("FAIL reload_pre run=%b want 1", bus0.cpu_run);
      end
      clearLog();
      startLoad(1);
      total++;
      if (bus0.cpu_run !== 1'b0 || bus0.busy !== 1'b1) begin
         bad++;
         $display("FAIL reload_drop run=%b busy=%b want 0/1", bus0.cpu_run, bus0.busy);
      end
      sendByte(8'hDE);
      sendByte(8'hAD);
      sendByte(8'hBE);
      sendByte(8'hEF);
      total++;
      if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL reload_write we=%b got=%h@%h want 1 deadbeef@00000000",
                  bus0.mem_we, bus0.mem_wdata, bus0.mem_addr);
      end
      tick();
      total++;
      if (bus0.cpu_run !== 1'b1 || logAddr.size() != 1) begin
         bad++;
         $display("FAIL reload_run run=%b writes=%0d want 1/1", bus0.cpu_run, logAddr.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_err();
      test_abort();
      test_reload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-fetch interface: streams a program into instruction memory, which the DataPath later reads by PC.
- Accepts bytes over a valid/ready handshake, packs them big-endian into 32-bit words, and issues one memory write per word at PC-compatible byte addresses.
- Holds the CPU in reset through cpu_run until the whole program is written, then releases it.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first instruction word (the reset PC).
- MAX_WORDS, 256, largest accepted program length in words.
- CNT_W, 9, width of the word-count input; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- load_words  input  CNT_W  program length in words; sampled together with load_start.
- byte_in  input  8  program byte stream, first byte = MSB of word 0.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader accepts byte_in this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the write, BASE_ADDR + 4*word_index.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in RECV and WRITE.
- cpu_run  output  1  high only in DONE; the DataPath is held in reset while this is low.
- load_err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset, synchronous and active-high:
  - State goes to IDLE.
  - All outputs reset to 0: byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_run, load_err.
  - Byte counter, word index and shift register are cleared.
  - Reset asserted mid-load aborts the load immediately; no partial word is written afterwards.
- State IDLE:
  - If load_start=1 and load_words=0: go to DONE. No writes.
  - If load_start=1 and load_words>MAX_WORDS: pulse load_err for 1 cycle and stay in IDLE.
  - If load_start=1 otherwise: latch load_words, clear word_index and byte_cnt, go to RECV.
- State RECV:
  - byte_ready=1.
  - A byte transfers only when byte_valid && byte_ready: shift register becomes {shift[23:0], byte_in} and byte_cnt increments mod 4.
  - When the 4th byte transfers (byte_cnt 3->0), go to WRITE on the next edge.
  - byte_valid=0 stalls indefinitely; there is no timeout.
  - load_start is ignored in this state.
- State WRITE, exactly 1 cycle:
  - mem_we=1, mem_wdata=shift register, mem_addr=BASE_ADDR + {word_index, 2'b00}, byte_ready=0.
  - If word_index+1 == latched length: go to DONE. Otherwise increment word_index and return to RECV.
- State DONE:
  - cpu_run=1, held until reset or a new load_start.
  - load_start in DONE is handled as in IDLE. An accepted new load drops cpu_run on the same edge it enters RECV.
  - A rejected request pulses load_err and stays in DONE, so cpu_run remains 1.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Arithmetic: word_index is CNT_W bits; address addition is 32-bit and wraps modulo 2^32 without error.
- Throughput: with byte_valid held at 1, each word takes 5 cycles (4 RECV + 1 WRITE).
- Latency: the last write pulse occurs 1 cycle after its 4th byte, and cpu_run rises 1 cycle after that last write.

Test Plan:
- Reset then load_words=2, bytes 8C,01,00,04,AC,02,00,08 with byte_valid continuous -> mem_we pulses at cycles 5 and 10 after start, writing 8C010004@00000000 and AC020008@00000004; cpu_run rises at cycle 11 and busy=0 afterwards.
- Same load with byte_valid deasserted for 3 cycles after byte 2 -> byte_ready stays 1, no write until byte 4 arrives, and the data is identical.
- load_words=0 -> cpu_run=1 on the next cycle and mem_we never asserts; load_words=257 (MAX_WORDS=256) -> load_err pulses once, state stays IDLE and cpu_run=0.
- Reset asserted after 6 bytes of a 2-word load -> outputs go to 0 next cycle and no second write occurs; a new load then starts cleanly at address 00000000.
- From DONE, a new load_start with load_words=1 -> cpu_run falls on the same edge, the word is written to 00000000, and cpu_run is re-asserted.
- BASE_ADDR=FFFFFFFC with load_words=2 -> the writes go to FFFFFFFC and then 00000000.
